// File: rtl/triangle_feeder.sv
// -----------------------------------------------------------------------------
// triangle_feeder
//
// Front end of the rasterizer. It walks an indexed triangle list and hands the
// rasterizer one fully assembled triangle per valid/ready transfer.
//
// Each triangle is fetched in a fixed five-cycle pipelined window:
//   f=0..2  index memory is read at 3*t+f
//   f=0     color memory is read at t
//   f=1..3  each returned vertex index is forwarded straight to vertex memory
//   f=1     the color index is captured
//   f=2..4  the returned {z,y,x} words are captured into v0, v1, v2
// The triangle is then presented until the rasterizer accepts it.
//
// Ports
//   clk, rstn         clock, asynchronous active-low reset
//   i_start           begin a list (sampled only while idle)
//   i_num_triangles   list length, clamped to MAX_TRIANGLES when latched
//   o_idx_addr        index memory address     / i_idx_data   (1-cycle latency)
//   o_vtx_addr        vertex memory address    / i_vtx_data   (1-cycle latency)
//   o_color_addr      color memory address     / i_color_data (1-cycle latency)
//   o_v0..o_v2        {z,y,x} of the presented triangle
//   o_color           color lookup index of the presented triangle
//   o_triangle_dv     triangle valid
//   o_triangle_last   valid triangle is the final one of the list
//   i_ready           rasterizer accepts the triangle when high with o_triangle_dv
//   o_busy            high whenever not idle
//   o_done            one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module triangle_feeder #(
  parameter int unsigned DATAWIDTH      = 12,
  parameter int unsigned COLORWIDTH     = 4,
  parameter int unsigned VTX_ADDR_WIDTH = 8,
  parameter int unsigned MAX_TRIANGLES  = 256,
  parameter int unsigned TRI_WIDTH      = $clog2(MAX_TRIANGLES + 1),
  parameter int unsigned IDX_ADDR_WIDTH = $clog2(3 * MAX_TRIANGLES)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_start,
  input  logic [TRI_WIDTH-1:0]      i_num_triangles,
  output logic [IDX_ADDR_WIDTH-1:0] o_idx_addr,
  input  logic [VTX_ADDR_WIDTH-1:0] i_idx_data,
  output logic [VTX_ADDR_WIDTH-1:0] o_vtx_addr,
  input  logic [3*DATAWIDTH-1:0]    i_vtx_data,
  output logic [TRI_WIDTH-1:0]      o_color_addr,
  input  logic [COLORWIDTH-1:0]     i_color_data,
  output logic [3*DATAWIDTH-1:0]    o_v0,
  output logic [3*DATAWIDTH-1:0]    o_v1,
  output logic [3*DATAWIDTH-1:0]    o_v2,
  output logic [COLORWIDTH-1:0]     o_color,
  output logic                      o_triangle_dv,
  output logic                      o_triangle_last,
  input  logic                      i_ready,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam logic [TRI_WIDTH-1:0] MaxCount = TRI_WIDTH'(MAX_TRIANGLES);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StPresent,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Fetch-cycle counter (f), triangle number (t) and latched list length.
  logic [2:0]                fetch_cnt_q, fetch_cnt_d;
  logic [TRI_WIDTH-1:0]      tri_q, tri_d;
  logic [TRI_WIDTH-1:0]      count_q, count_d;

  logic [IDX_ADDR_WIDTH-1:0] idx_addr_q, idx_addr_d;
  logic [VTX_ADDR_WIDTH-1:0] vtx_addr_q, vtx_addr_d;
  logic [TRI_WIDTH-1:0]      color_addr_q, color_addr_d;

  logic [3*DATAWIDTH-1:0]    v0_q, v0_d;
  logic [3*DATAWIDTH-1:0]    v1_q, v1_d;
  logic [3*DATAWIDTH-1:0]    v2_q, v2_d;
  logic [COLORWIDTH-1:0]     color_q, color_d;

  logic is_last;
  logic fetch_end;
  logic vtx_window;
  logic xfer;

  assign is_last    = (tri_q == (count_q - TRI_WIDTH'(1)));
  assign fetch_end  = (state_q == StFetch) && (fetch_cnt_q == 3'd4);
  // f=1..3: index data is arriving and is forwarded as the vertex address.
  assign vtx_window = (state_q == StFetch) && (fetch_cnt_q >= 3'd1) && (fetch_cnt_q <= 3'd3);
  assign xfer       = (state_q == StPresent) && i_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = (i_num_triangles == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (fetch_end) begin
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (i_ready) begin
          state_d = is_last ? StDone : StFetch;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_triangle_dv   = (state_q == StPresent);
    o_triangle_last = (state_q == StPresent) && is_last;
    o_busy          = (state_q != StIdle);
    o_done          = (state_q == StDone);
    o_idx_addr      = idx_addr_q;
    o_color_addr    = color_addr_q;
    // Same-cycle pass-through keeps the vertex read one cycle behind the index
    // read; outside the window the last issued address is held.
    o_vtx_addr      = vtx_window ? i_idx_data : vtx_addr_q;
    o_v0            = v0_q;
    o_v1            = v1_q;
    o_v2            = v2_q;
    o_color         = color_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_cnt_d  = '0;
    tri_d        = tri_q;
    count_d      = count_q;
    idx_addr_d   = idx_addr_q;
    vtx_addr_d   = vtx_addr_q;
    color_addr_d = color_addr_q;
    v0_d         = v0_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    color_d      = color_q;

    unique case (state_q)
      StIdle: begin
        if (i_start && (i_num_triangles != '0)) begin
          count_d      = (i_num_triangles > MaxCount) ? MaxCount : i_num_triangles;
          tri_d        = '0;
          // Addresses are loaded one cycle early so f=0 already drives them.
          idx_addr_d   = '0;
          color_addr_d = '0;
        end
      end

      StFetch: begin
        if (!fetch_end) begin
          fetch_cnt_d = fetch_cnt_q + 3'd1;
        end
        if (fetch_cnt_q < 3'd2) begin
          idx_addr_d = idx_addr_q + IDX_ADDR_WIDTH'(1);
        end
        if (vtx_window) begin
          vtx_addr_d = i_idx_data;
        end
        unique case (fetch_cnt_q)
          3'd1:    color_d = i_color_data;
          3'd2:    v0_d    = i_vtx_data;
          3'd3:    v1_d    = i_vtx_data;
          3'd4:    v2_d    = i_vtx_data;
          default: ;
        endcase
      end

      StPresent: begin
        if (xfer && !is_last) begin
          tri_d        = tri_q + TRI_WIDTH'(1);
          // idx_addr_q sits at 3*t+2, so the next base 3*(t+1) is one above it.
          idx_addr_d   = idx_addr_q + IDX_ADDR_WIDTH'(1);
          color_addr_d = tri_q + TRI_WIDTH'(1);
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_cnt_q  <= '0;
      tri_q        <= '0;
      count_q      <= '0;
      idx_addr_q   <= '0;
      vtx_addr_q   <= '0;
      color_addr_q <= '0;
      v0_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      color_q      <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      tri_q        <= tri_d;
      count_q      <= count_d;
      idx_addr_q   <= idx_addr_d;
      vtx_addr_q   <= vtx_addr_d;
      color_addr_q <= color_addr_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      color_q      <= color_d;
    end
  end

endmodule

// File: tb/tb_triangle_feeder.sv
module tb_triangle_feeder;

  localparam int unsigned DW   = 12;
  localparam int unsigned CW   = 4;
  localparam int unsigned VAW  = 8;
  localparam int unsigned MAXT = 256;
  localparam int unsigned TW   = $clog2(MAXT + 1);
  localparam int unsigned IAW  = $clog2(3 * MAXT);

  localparam logic [35:0] VTX0 = {12'h800, 12'd30, 12'd30};
  localparam logic [35:0] VTX1 = {12'h400, 12'd100, 12'd140};
  localparam logic [35:0] VTX2 = {12'h400, 12'd0, 12'd160};
  localparam logic [35:0] VTX3 = {12'h200, 12'd50, 12'd70};

  logic            clk;
  logic            rstn;
  logic            i_start;
  logic [TW-1:0]   i_num_triangles;
  logic [IAW-1:0]  o_idx_addr;
  logic [VAW-1:0]  i_idx_data;
  logic [VAW-1:0]  o_vtx_addr;
  logic [3*DW-1:0] i_vtx_data;
  logic [TW-1:0]   o_color_addr;
  logic [CW-1:0]   i_color_data;
  logic [3*DW-1:0] o_v0;
  logic [3*DW-1:0] o_v1;
  logic [3*DW-1:0] o_v2;
  logic [CW-1:0]   o_color;
  logic            o_triangle_dv;
  logic            o_triangle_last;
  logic            i_ready;
  logic            o_busy;
  logic            o_done;

  logic [VAW-1:0]  idx_mem [1024];
  logic [3*DW-1:0] vtx_mem [256];
  logic [CW-1:0]   col_mem [512];

  int n_tests = 0;
  int n_fail  = 0;
  int xfer_cnt = 0;
  int last_cnt = 0;
  int done_cnt = 0;

  triangle_feeder dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_start         (i_start),
    .i_num_triangles (i_num_triangles),
    .o_idx_addr      (o_idx_addr),
    .i_idx_data      (i_idx_data),
    .o_vtx_addr      (o_vtx_addr),
    .i_vtx_data      (i_vtx_data),
    .o_color_addr    (o_color_addr),
    .i_color_data    (i_color_data),
    .o_v0            (o_v0),
    .o_v1            (o_v1),
    .o_v2            (o_v2),
    .o_color         (o_color),
    .o_triangle_dv   (o_triangle_dv),
    .o_triangle_last (o_triangle_last),
    .i_ready         (i_ready),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory models, one cycle of latency each.
  always @(posedge clk) begin
    i_idx_data   <= idx_mem[o_idx_addr];
    i_vtx_data   <= vtx_mem[o_vtx_addr];
    i_color_data <= col_mem[o_color_addr];
  end

  // Transfer / last / done event counters.
  always @(posedge clk) begin
    if (o_triangle_dv && i_ready) begin
      xfer_cnt = xfer_cnt + 1;
      if (o_triangle_last) last_cnt = last_cnt + 1;
    end
    if (o_done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [TW-1:0] n);
    i_start         = 1'b1;
    i_num_triangles = n;
    tick();
    i_start         = 1'b0;
  endtask

  // Entered at f=0; returns in the first PRESENT cycle.
  task automatic fetch_and_check(input logic [IAW-1:0] base, input logic [TW-1:0] tno,
                                 input logic [35:0] e0, input logic [35:0] e1,
                                 input logic [35:0] e2, input logic [3:0] ec,
                                 input logic el);
    logic [IAW-1:0] a;
    check("f0_idx_addr", 64'(o_idx_addr), 64'(base));
    check("f0_color_addr", 64'(o_color_addr), 64'(tno));
    check("f0_busy", 64'(o_busy), 64'(1'b1));
    tick();
    a = base;
    check("f1_idx_addr", 64'(o_idx_addr), 64'(base + IAW'(1)));
    check("f1_vtx_addr", 64'(o_vtx_addr), 64'(idx_mem[a]));
    tick();
    a = base + IAW'(1);
    check("f2_idx_addr", 64'(o_idx_addr), 64'(base + IAW'(2)));
    check("f2_vtx_addr", 64'(o_vtx_addr), 64'(idx_mem[a]));
    tick();
    a = base + IAW'(2);
    check("f3_vtx_addr", 64'(o_vtx_addr), 64'(idx_mem[a]));
    tick();
    check("f4_dv_low", 64'(o_triangle_dv), 64'(1'b0));
    tick();
    check("pr_dv", 64'(o_triangle_dv), 64'(1'b1));
    check("pr_last", 64'(o_triangle_last), 64'(el));
    check("pr_v0", 64'(o_v0), 64'(e0));
    check("pr_v1", 64'(o_v1), 64'(e1));
    check("pr_v2", 64'(o_v2), 64'(e2));
    check("pr_color", 64'(o_color), 64'(ec));
  endtask

  initial begin
    int x0;
    int max_idx;
    logic saw_done;

    rstn            = 1'b0;
    i_start         = 1'b0;
    i_ready         = 1'b0;
    i_num_triangles = '0;
    for (int i = 0; i < 1024; i++) idx_mem[i] = '0;
    for (int i = 0; i < 256; i++) vtx_mem[i] = 36'(i * 3 + 1);
    for (int i = 0; i < 512; i++) col_mem[i] = 4'(i);
    vtx_mem[0] = VTX0;
    vtx_mem[1] = VTX1;
    vtx_mem[2] = VTX2;
    vtx_mem[3] = VTX3;
    col_mem[0] = 4'd3;
    col_mem[1] = 4'd9;
    col_mem[2] = 4'd6;

    // Reset state
    tick();
    tick();
    check("rst_dv", 64'(o_triangle_dv), 64'(1'b0));
    check("rst_busy", 64'(o_busy), 64'(1'b0));
    check("rst_done", 64'(o_done), 64'(1'b0));
    check("rst_idx_addr", 64'(o_idx_addr), 64'(0));
    check("rst_v0", 64'(o_v0), 64'(0));
    rstn = 1'b1;
    tick();

    // Single triangle
    idx_mem[0] = 8'd0; idx_mem[1] = 8'd1; idx_mem[2] = 8'd2;
    i_ready = 1'b1;
    x0 = xfer_cnt;
    start(TW'(1));
    fetch_and_check(IAW'(0), TW'(0), VTX0, VTX1, VTX2, 4'd3, 1'b1);
    tick();
    check("t1_done", 64'(o_done), 64'(1'b1));
    check("t1_done_busy", 64'(o_busy), 64'(1'b1));
    check("t1_done_dv", 64'(o_triangle_dv), 64'(1'b0));
    tick();
    check("t1_idle_done", 64'(o_done), 64'(1'b0));
    check("t1_idle_busy", 64'(o_busy), 64'(1'b0));
    check("t1_xfers", 64'(xfer_cnt - x0), 64'(1));

    // Two triangles sharing vertices
    idx_mem[3] = 8'd0; idx_mem[4] = 8'd3; idx_mem[5] = 8'd2;
    x0 = xfer_cnt;
    start(TW'(2));
    fetch_and_check(IAW'(0), TW'(0), VTX0, VTX1, VTX2, 4'd3, 1'b0);
    tick();
    fetch_and_check(IAW'(3), TW'(1), VTX0, VTX3, VTX2, 4'd9, 1'b1);
    tick();
    check("t2_done", 64'(o_done), 64'(1'b1));
    tick();
    check("t2_xfers", 64'(xfer_cnt - x0), 64'(2));

    // Backpressure, plus an i_start that must be ignored while busy
    i_ready = 1'b0;
    x0 = xfer_cnt;
    start(TW'(1));
    fetch_and_check(IAW'(0), TW'(0), VTX0, VTX1, VTX2, 4'd3, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        i_start         = 1'b1;
        i_num_triangles = TW'(7);
      end
      tick();
      i_start = 1'b0;
      check("bp_dv", 64'(o_triangle_dv), 64'(1'b1));
      check("bp_last", 64'(o_triangle_last), 64'(1'b1));
      check("bp_v0", 64'(o_v0), 64'(VTX0));
      check("bp_v1", 64'(o_v1), 64'(VTX1));
      check("bp_v2", 64'(o_v2), 64'(VTX2));
      check("bp_color", 64'(o_color), 64'(4'd3));
      check("bp_idx_hold", 64'(o_idx_addr), 64'(2));
    end
    check("bp_no_xfer", 64'(xfer_cnt - x0), 64'(0));
    i_ready = 1'b1;
    tick();
    check("bp_done", 64'(o_done), 64'(1'b1));
    check("bp_one_xfer", 64'(xfer_cnt - x0), 64'(1));
    tick();

    // Zero count
    x0 = xfer_cnt;
    start(TW'(0));
    check("z_done", 64'(o_done), 64'(1'b1));
    check("z_dv", 64'(o_triangle_dv), 64'(1'b0));
    tick();
    check("z_idle", 64'(o_busy), 64'(1'b0));
    check("z_no_xfer", 64'(xfer_cnt - x0), 64'(0));

    // Reset during fetch of triangle 1 of 3
    idx_mem[6] = 8'd1; idx_mem[7] = 8'd2; idx_mem[8] = 8'd3;
    start(TW'(3));
    fetch_and_check(IAW'(0), TW'(0), VTX0, VTX1, VTX2, 4'd3, 1'b0);
    tick();
    tick();
    x0 = done_cnt;
    rstn = 1'b0;
    #1;
    check("mr_busy", 64'(o_busy), 64'(1'b0));
    check("mr_idx_addr", 64'(o_idx_addr), 64'(0));
    check("mr_color_addr", 64'(o_color_addr), 64'(0));
    check("mr_vtx_addr", 64'(o_vtx_addr), 64'(0));
    check("mr_v0", 64'(o_v0), 64'(0));
    check("mr_v1", 64'(o_v1), 64'(0));
    check("mr_color", 64'(o_color), 64'(0));
    tick();
    rstn = 1'b1;
    tick();
    tick();
    check("mr_no_done", 64'(done_cnt - x0), 64'(0));
    start(TW'(1));
    fetch_and_check(IAW'(0), TW'(0), VTX0, VTX1, VTX2, 4'd3, 1'b1);
    tick();
    check("mr_restart_done", 64'(o_done), 64'(1'b1));
    tick();

    // Clamp: count above MAX_TRIANGLES
    for (int a = 0; a < 3 * MAXT; a++) idx_mem[a] = 8'(a);
    x0 = xfer_cnt;
    last_cnt = 0;
    max_idx = 0;
    saw_done = 1'b0;
    start(TW'(MAXT + 5));
    for (int c = 0; c < 5000; c++) begin
      if (int'(o_idx_addr) > max_idx) max_idx = int'(o_idx_addr);
      if (o_done) begin
        saw_done = 1'b1;
        break;
      end
      tick();
    end
    check("cl_done_seen", 64'(saw_done), 64'(1'b1));
    check("cl_xfers", 64'(xfer_cnt - x0), 64'(MAXT));
    check("cl_last_once", 64'(last_cnt), 64'(1));
    check("cl_max_idx", 64'(max_idx), 64'(3 * MAXT - 1));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
